rca_config_sequencer: RTL and testbench
=======================================

RCA_CONFIG_SEQUENCER -- requirements
Module: rca_config_sequencer

Interface
REQ-001 SHALL have parameter NUM_RCAS, default 4, the number of RCAs addressed by funct7.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the number of config-instruction queue entries (power of 2).
REQ-003 SHALL have parameter NUM_GRID_MUXES, default 72, the number of legal grid-MUX indices (rs1).
REQ-004 SHALL have parameter NUM_IO_UNITS, default 13, the number of legal IO-unit-MUX indices (rs1).
REQ-005 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port issue_valid, input, 1, a config instruction is offered.
REQ-008 SHALL have port issue_ready, output, 1, the offered instruction is accepted this cycle.
REQ-009 SHALL have ports issue_funct3 (input, 3), issue_funct7 (input, 7), issue_rs1 (input, 32) and issue_rs2 (input, 32), carrying the instruction fields.
REQ-010 SHALL have ports cfg_we (output, 1), cfg_type (output, 3), cfg_rca_id (output, 2), cfg_sel (output, 7) and cfg_value (output, 32), forming the registered write request to the RCA config storage.
REQ-011 SHALL have port cfg_ack, input, 1, the config storage consumes the current write.
REQ-012 SHALL have ports use_valid (input, 1), use_rca_id (input, 2) and use_grant (output, 1), the RCA-use permission check.
REQ-013 SHALL have port err_illegal, output, 1, a one-cycle pulse on discard of an illegal instruction.

Function
REQ-014 SHALL treat as legal config: funct3 001 (CPU reg), 100 (result MUX) and 101 (IO use), each requiring funct7<NUM_RCAS; 010 (grid MUX), requiring rs1<NUM_GRID_MUXES; and 011 (IO unit MUX), requiring rs1<NUM_IO_UNITS.
REQ-015 SHALL classify funct3 000, 110 and 111, and any failed range check, as illegal.
REQ-016 SHALL compute issue_ready = !full, combinationally, with no bypass when full.
REQ-017 SHALL, on issue_valid&&issue_ready: enqueue legal instructions; for illegal ones, pulse err_illegal the next cycle, enqueue nothing and change no counter.
REQ-018 SHALL fill each FIFO entry as: type=funct3; rca_id=funct7[1:0] for per-RCA types and 0 for 010/011; sel=rs1[6:0]; value=rs2.
REQ-019 SHALL implement an FSM with states IDLE and DRIVE.
REQ-020 SHALL transition IDLE->DRIVE when the FIFO is non-empty, loading the head entry into the cfg_* outputs and driving cfg_we=1 in the next cycle.
REQ-021 SHALL, in DRIVE, hold all cfg_* outputs stable while cfg_ack=0.
REQ-022 SHALL, on cfg_ack=1 in DRIVE, pop the head entry; if another entry remains, present it in the next cycle and stay in DRIVE, otherwise go to IDLE with cfg_we=0.
REQ-023 SHALL sustain one write per cycle when cfg_ack is held high.
REQ-024 SHALL give minimum latency accept->cfg_we of 2 cycles from an empty FIFO in IDLE.
REQ-025 SHALL ignore cfg_ack in IDLE.
REQ-026 SHALL maintain pend[NUM_RCAS] (3-bit) for per-RCA types and a global pend_g (3-bit) for types 010/011, incremented on enqueue and decremented on the ack of that entry.
REQ-027 SHALL leave a counter unchanged on a simultaneous increment and decrement of it.
REQ-028 SHALL never wrap counters; saturation is unreachable with FIFO_DEPTH<=7.
REQ-029 SHALL compute use_grant = use_valid && pend[use_rca_id]==0 && pend_g==0, combinationally.
REQ-030 SHALL drive use_grant=0 when use_rca_id>=NUM_RCAS.
REQ-031 SHALL accept an enqueue while full and popping in the same cycle only on the following cycle, since ready does not depend on cfg_ack.

Reset
REQ-032 SHALL, on rst asserted (at any time, including mid-DRIVE): empty the FIFO, enter IDLE, clear all counters, and set cfg_we=0, cfg_type/cfg_rca_id/cfg_sel/cfg_value=0 and err_illegal=0.
REQ-033 SHALL drive issue_ready=1 after reset.
REQ-034 SHALL discard any in-flight write on reset without issuing an ack.

Verification
REQ-035 SHALL cover: single write — issue funct3=001, funct7=2, rs1=0x13, rs2=5, cfg_ack=1 -> cfg_we high exactly 1 cycle, 2 cycles after accept, with type=1, rca_id=2, sel=0x13, value=5.
REQ-036 SHALL cover: backpressure — issue 5 legal instrs with cfg_ack=0 -> issue_ready=0 after the 4th accept; cfg_* stable; releasing ack -> 4 back-to-back writes.
REQ-037 SHALL cover: illegal — funct3=010 with rs1=72, funct3=100 with funct7=4, and funct3=000 -> 3 err_illegal pulses, no cfg_we, counters stay 0.
REQ-038 SHALL cover: use blocking — queue funct3=101 for RCA1 -> use_grant=0 for id 1, =1 for id 0; a queued funct3=011 -> grant=0 for all ids until its ack.
REQ-039 SHALL cover: reset mid-DRIVE — 3 entries queued, rst pulsed -> cfg_we=0 the same cycle, issue_ready=1, use_grant=1 for all ids afterwards.
REQ-040 SHALL cover: simultaneous — enqueue for RCA0 on the cycle the RCA0 entry is acked -> pend[0] unchanged and grant stays 0.

Source files
------------

// File: rtl/rca_config_sequencer.sv
// Config-instruction sequencer: validates RCA config instructions, queues them, and drives
// one registered write at a time into RCA config storage while tracking per-RCA pending writes.
module rca_config_sequencer #(
  parameter int unsigned NUM_RCAS       = 4,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned NUM_GRID_MUXES = 72,
  parameter int unsigned NUM_IO_UNITS   = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [2:0]  issue_funct3,
  input  logic [6:0]  issue_funct7,
  input  logic [31:0] issue_rs1,
  input  logic [31:0] issue_rs2,
  output logic        cfg_we,
  output logic [2:0]  cfg_type,
  output logic [1:0]  cfg_rca_id,
  output logic [6:0]  cfg_sel,
  output logic [31:0] cfg_value,
  input  logic        cfg_ack,
  input  logic        use_valid,
  input  logic [1:0]  use_rca_id,
  output logic        use_grant,
  output logic        err_illegal
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [2:0]  ftype;
    logic [1:0]  rca_id;
    logic [6:0]  sel;
    logic [31:0] value;
  } entry_t;

  typedef enum logic [0:0] {StIdle, StDrive} state_e;

  state_e          state_q;
  entry_t          fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q, next_rd_ptr;
  logic [CntW-1:0] count_q;
  logic [2:0]      pend_q [NUM_RCAS];
  logic [2:0]      pend_d [NUM_RCAS];
  logic [2:0]      pend_g_q, pend_g_d;

  logic   legal, per_rca, is_global, accept, push, pop;
  logic   cfg_per_rca, cfg_global;
  entry_t new_entry;

  always_comb begin
    legal     = 1'b0;
    per_rca   = 1'b0;
    is_global = 1'b0;
    case (issue_funct3)
      3'b001, 3'b100, 3'b101: begin
        per_rca = 1'b1;
        legal   = 32'(issue_funct7) < NUM_RCAS;
      end
      3'b010: begin
        is_global = 1'b1;
        legal     = issue_rs1 < NUM_GRID_MUXES;
      end
      3'b011: begin
        is_global = 1'b1;
        legal     = issue_rs1 < NUM_IO_UNITS;
      end
      default: ;
    endcase
  end

  assign issue_ready      = (count_q != CntW'(FIFO_DEPTH));
  assign accept           = issue_valid && issue_ready;
  assign push             = accept && legal;
  assign pop              = (state_q == StDrive) && cfg_ack;
  assign next_rd_ptr      = rd_ptr_q + PtrW'(1);
  assign new_entry.ftype  = issue_funct3;
  assign new_entry.rca_id = per_rca ? issue_funct7[1:0] : 2'd0;
  assign new_entry.sel    = issue_rs1[6:0];
  assign new_entry.value  = issue_rs2;

  // Only legal types are ever queued, so anything not per-RCA is global.
  assign cfg_global  = (cfg_type == 3'b010) || (cfg_type == 3'b011);
  assign cfg_per_rca = !cfg_global;

  always_comb begin
    for (int i = 0; i < int'(NUM_RCAS); i++) begin
      logic inc, dec;
      inc       = push && per_rca && (new_entry.rca_id == 2'(i));
      dec       = pop && cfg_per_rca && (cfg_rca_id == 2'(i));
      pend_d[i] = pend_q[i];
      if (inc && !dec) pend_d[i] = pend_q[i] + 3'd1;
      else if (dec && !inc) pend_d[i] = pend_q[i] - 3'd1;
    end
    pend_g_d = pend_g_q;
    if (push && is_global && !(pop && cfg_global)) pend_g_d = pend_g_q + 3'd1;
    else if (pop && cfg_global && !(push && is_global)) pend_g_d = pend_g_q - 3'd1;
  end

  always_comb begin
    logic       id_ok;
    logic [2:0] sel_pend;
    id_ok    = 1'b0;
    sel_pend = 3'd0;
    for (int i = 0; i < int'(NUM_RCAS); i++) begin
      if (use_rca_id == 2'(i)) begin
        id_ok    = 1'b1;
        sel_pend = pend_q[i];
      end
    end
    use_grant = use_valid && id_ok && (sel_pend == 3'd0) && (pend_g_q == 3'd0);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= new_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      pend_g_q    <= '0;
      err_illegal <= 1'b0;
      for (int i = 0; i < int'(NUM_RCAS); i++) pend_q[i] <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) rd_ptr_q <= next_rd_ptr;
      count_q     <= count_q + CntW'(push) - CntW'(pop);
      pend_g_q    <= pend_g_d;
      err_illegal <= accept && !legal;
      for (int i = 0; i < int'(NUM_RCAS); i++) pend_q[i] <= pend_d[i];
    end
  end

  // The presented entry stays in the FIFO until acked, so count_q includes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cfg_we     <= 1'b0;
      cfg_type   <= '0;
      cfg_rca_id <= '0;
      cfg_sel    <= '0;
      cfg_value  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (count_q != '0) begin
            {cfg_type, cfg_rca_id, cfg_sel, cfg_value} <= fifo_q[rd_ptr_q];
            cfg_we  <= 1'b1;
            state_q <= StDrive;
          end
        end
        StDrive: begin
          if (cfg_ack) begin
            if (count_q > CntW'(1)) begin
              {cfg_type, cfg_rca_id, cfg_sel, cfg_value} <= fifo_q[next_rd_ptr];
            end else begin
              cfg_we  <= 1'b0;
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_config_sequencer.sv
// Directed plus randomized bench for rca_config_sequencer, checked every cycle against a
// queue-based reference model of the instruction stream.
module tb_rca_config_sequencer;

  localparam int NUM_RCAS = 4;
  localparam int DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_ready;
  logic [2:0]  issue_funct3;
  logic [6:0]  issue_funct7;
  logic [31:0] issue_rs1, issue_rs2;
  logic        cfg_we;
  logic [2:0]  cfg_type;
  logic [1:0]  cfg_rca_id;
  logic [6:0]  cfg_sel;
  logic [31:0] cfg_value;
  logic        cfg_ack;
  logic        use_valid;
  logic [1:0]  use_rca_id;
  logic        use_grant;
  logic        err_illegal;

  rca_config_sequencer #(
    .NUM_RCAS      (NUM_RCAS),
    .FIFO_DEPTH    (DEPTH),
    .NUM_GRID_MUXES(72),
    .NUM_IO_UNITS  (13)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_funct3(issue_funct3),
    .issue_funct7(issue_funct7),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .cfg_we      (cfg_we),
    .cfg_type    (cfg_type),
    .cfg_rca_id  (cfg_rca_id),
    .cfg_sel     (cfg_sel),
    .cfg_value   (cfg_value),
    .cfg_ack     (cfg_ack),
    .use_valid   (use_valid),
    .use_rca_id  (use_rca_id),
    .use_grant   (use_grant),
    .err_illegal (err_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  t;
    logic [1:0]  id;
    logic [6:0]  sel;
    logic [31:0] val;
  } ent_t;

  ent_t q[$];
  ent_t m_cfg;
  bit   m_we, m_err;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_per_rca(input logic [2:0] t);
    return (t == 3'b001) || (t == 3'b100) || (t == 3'b101);
  endfunction

  function automatic bit is_legal(input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] rs1);
    if (is_per_rca(f3)) return int'(f7) < NUM_RCAS;
    if (f3 == 3'b010) return rs1 < 32'd72;
    if (f3 == 3'b011) return rs1 < 32'd13;
    return 1'b0;
  endfunction

  // An RCA may be used only when nothing queued or in flight targets it or the shared grid.
  function automatic bit m_grant(input logic v, input logic [1:0] id);
    if (!v || int'(id) >= NUM_RCAS) return 1'b0;
    foreach (q[k]) begin
      if (!is_per_rca(q[k].t)) return 1'b0;
      if (q[k].id == id) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_cfg = '0;
    m_we  = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_step();
    bit   acc, lg;
    ent_t e;
    acc = issue_valid && (q.size() < DEPTH);
    lg  = is_legal(issue_funct3, issue_funct7, issue_rs1);
    if (!m_we) begin
      if (q.size() > 0) begin
        m_we  = 1'b1;
        m_cfg = q[0];
      end
    end else if (cfg_ack) begin
      void'(q.pop_front());
      if (q.size() > 0) m_cfg = q[0];
      else m_we = 1'b0;
    end
    if (acc && lg) begin
      e.t   = issue_funct3;
      e.id  = is_per_rca(issue_funct3) ? issue_funct7[1:0] : 2'd0;
      e.sel = issue_rs1[6:0];
      e.val = issue_rs2;
      q.push_back(e);
    end
    m_err = acc && !lg;
  endtask

  task automatic drive(input logic v, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic ack,
                       input logic uv, input logic [1:0] uid);
    issue_valid  = v;
    issue_funct3 = f3;
    issue_funct7 = f7;
    issue_rs1    = rs1;
    issue_rs2    = rs2;
    cfg_ack      = ack;
    use_valid    = uv;
    use_rca_id   = uid;
  endtask

  // Check every output against the model, then advance one clock.
  task automatic tick();
    #1;
    chk("issue_ready", issue_ready, q.size() < DEPTH);
    chk("cfg_we", cfg_we, m_we);
    chk("cfg_type", cfg_type, m_cfg.t);
    chk("cfg_rca_id", cfg_rca_id, m_cfg.id);
    chk("cfg_sel", cfg_sel, m_cfg.sel);
    chk("cfg_value", cfg_value, m_cfg.val);
    chk("err_illegal", err_illegal, m_err);
    chk("use_grant", use_grant, m_grant(use_valid, use_rca_id));
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    issue_valid = 1'b0;
    use_valid   = 1'b1;
    #1;
    model_reset();
    chk("rst_cfg_we", cfg_we, 0);
    chk("rst_ready", issue_ready, 1);
    chk("rst_err", err_illegal, 0);
    chk("rst_fields", {cfg_type, cfg_rca_id, cfg_sel, cfg_value[19:0]}, 0);
    for (int id = 0; id < 4; id++) begin
      use_rca_id = 2'(id);
      #1;
      chk("rst_grant", use_grant, id < NUM_RCAS);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Single write: cfg_we rises two cycles after accept, for exactly one cycle.
    drive(1, 3'b001, 7'd2, 32'h13, 32'd5, 1, 1, 2);
    tick();
    issue_valid = 1'b0;
    chk("lat_cycle1_we", cfg_we, 0);
    tick();
    chk("lat_cycle2_we", cfg_we, 1);
    chk("single_fields", {cfg_type, cfg_rca_id, cfg_sel, cfg_value[15:0]},
        {3'd1, 2'd2, 7'h13, 16'd5});
    tick();
    chk("single_we_drop", cfg_we, 0);
    tick();

    // Backpressure: four fit, the fifth is refused until acks resume.
    for (int i = 0; i < 5; i++) begin
      drive(1, 3'b001, 7'(i % 4), 32'(i), 32'(100 + i), 0, 1, 2'(i));
      tick();
    end
    chk("bp_not_ready", issue_ready, 0);
    issue_valid = 1'b0;
    repeat (2) tick();
    cfg_ack = 1'b1;
    repeat (6) tick();

    // Illegal instructions: out-of-range rs1, funct7, and an unused funct3.
    drive(1, 3'b010, 7'd0, 32'd72, 32'd1, 1, 1, 0);
    tick();
    drive(1, 3'b100, 7'd4, 32'd1, 32'd2, 1, 1, 1);
    tick();
    drive(1, 3'b000, 7'd0, 32'd0, 32'd3, 1, 1, 2);
    tick();
    issue_valid = 1'b0;
    repeat (2) tick();

    // Use blocking by a per-RCA write, then by a global IO-unit write.
    drive(1, 3'b101, 7'd1, 32'd4, 32'd9, 0, 1, 1);
    tick();
    issue_valid = 1'b0;
    tick();
    use_rca_id = 2'd0;
    tick();
    drive(1, 3'b011, 7'd0, 32'd3, 32'd7, 0, 1, 0);
    tick();
    issue_valid = 1'b0;
    for (int id = 0; id < 4; id++) begin
      use_rca_id = 2'(id);
      tick();
    end
    cfg_ack = 1'b1;
    repeat (4) tick();

    // Reset while a write is being driven with more queued behind it.
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'b100, 7'(i), 32'(i + 8), 32'(i), 0, 1, 2'(i));
      tick();
    end
    issue_valid = 1'b0;
    tick();
    do_reset();
    tick();

    // Enqueue for RCA0 in the same cycle its earlier write is acked.
    drive(1, 3'b101, 7'd0, 32'd1, 32'd11, 0, 1, 0);
    tick();
    issue_valid = 1'b0;
    tick();
    drive(1, 3'b101, 7'd0, 32'd2, 32'd22, 1, 1, 0);
    tick();
    issue_valid = 1'b0;
    chk("simul_grant0", use_grant, 0);
    repeat (4) tick();

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), 7'($urandom_range(0, 5)),
              ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 80)) : 32'($urandom),
              32'($urandom), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)));
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
